reg_bus_arb: RTL and testbench
==============================

# reg_bus_arb

Arbitrates and sequences accesses to the register bank (the array of per-register read/write cells) between two requesters: the SPI frame handler and the eFuse loader. It accepts one request per transaction through a valid/ready handshake and grants round-robin. It drives a single-cycle write or read strobe onto the shared bank bus together with address, data, CRC and the access-mode enables. It captures the OR-reduced bank read data and returns it to the winning requester as a one-cycle response.

## Interface
- DW, 8, register data width
- AW, 8, register address width
- CRC_W, 8, per-register CRC width
- i_clk  in  1  clock, all logic on posedge
- i_rst_n  in  1  asynchronous active-low reset
- i_spi_req_vld  in  1  SPI request valid, held until accepted
- i_spi_req_wr  in  1  1 = write, 0 = read
- i_spi_req_addr  in  AW  SPI address
- i_spi_req_wdata  in  DW  SPI write data
- i_spi_req_crc  in  CRC_W  SPI write CRC
- o_spi_req_rdy  out  1  SPI request accepted this cycle
- o_spi_rsp_vld  out  1  SPI response pulse
- i_efu_req_vld / i_efu_req_wr / i_efu_req_addr / i_efu_req_wdata / i_efu_req_crc / o_efu_req_rdy / o_efu_rsp_vld  same as the SPI set, for the eFuse loader
- o_rsp_rdata  out  DW  response read data, shared by both requesters, 0 for writes
- o_rsp_rcrc  out  CRC_W  response read CRC, 0 for writes
- i_test_st_reg_en  in  1  test-state mode, passed through to the bus
- i_cfg_st_reg_en  in  1  config-state mode, passed through to the bus
- o_wen  out  1  bank write strobe
- o_ren  out  1  bank read strobe
- o_addr  out  AW  bank address
- o_wdata  out  DW  bank write data
- o_crc_data  out  CRC_W  bank write CRC
- o_test_st_reg_en / o_cfg_st_reg_en  out  1  registered copies of the mode inputs
- o_spi_ctrl_reg_en  out  1  high during an SPI-owned access
- o_efuse_ctrl_reg_en  out  1  high during an eFuse-owned access
- i_rdata  in  DW  OR of all bank o_rdata
- i_rcrc  in  CRC_W  OR of all bank o_rcrc

## Operation
- FSM states:
  - IDLE: default state.
  - ACC: exactly one cycle.
  - RSP: exactly one cycle.
- IDLE:
  - If no request is valid, stay in IDLE.
  - If exactly one request is valid, grant it.
  - If both are valid, grant the requester not granted last. The last-grant pointer resets to eFuse, so SPI wins the first tie.
  - In the grant cycle, assert the winner's rdy combinationally for one cycle; the loser's rdy stays 0.
  - On grant, latch wr/addr/wdata/crc and the owner into the command registers, update the last-grant pointer, go to ACC.
- ACC:
  - o_wen = latched wr, o_ren = !latched wr.
  - o_addr, o_wdata, o_crc_data come from the latched command.
  - Assert the owner's ctrl_reg_en; the other requester's ctrl_reg_en stays 0.
  - On a read, capture i_rdata/i_rcrc into the response registers; on a write, clear them to 0.
  - Go to RSP.
- RSP:
  - Pulse the owner's rsp_vld with o_rsp_rdata/o_rsp_rcrc valid.
  - Go to IDLE.
- Rules:
  - The bank bus is idle outside ACC: o_wen = o_ren = 0 and both ctrl_reg_en = 0. o_addr/o_wdata/o_crc_data hold their last value.
  - A read that hits no register, or is mode-blocked in the bank, returns 0. The arbiter does not flag it.
  - A requester may present its next request during ACC or RSP. It is accepted no earlier than the following IDLE cycle.
  - Mode passthrough registers update every cycle and are independent of the FSM.

## Timing
- Grant in cycle N (rdy=1) -> strobe in N+1 -> rsp_vld in N+2 -> earliest next grant in N+3. Peak throughput is one access per 3 cycles.
- Bank read is combinational. i_rdata is sampled at the end of the ACC cycle, and a bank write from the same strobe does not affect it.
- Reset values:
  - All outputs 0.
  - FSM in IDLE, last-grant pointer = eFuse, command and response registers 0.
- Reset asserted mid-transaction aborts it asynchronously: strobe drops immediately and no rsp_vld is issued.
- rdy is combinational from vld and state. There is no combinational path from i_rdata to any output.

## Structure
- Shared package reg_bus_pkg holds:
  - the FSM state enum (IDLE, ACC, RSP);
  - the owner enum (OWN_SPI, OWN_EFU);
  - a packed command struct (wr, addr, wdata, crc).
- One natural sub-module, rr_arb2: the 2-way round-robin grant with last-grant pointer. Everything else stays in the top.
- Estimated 150–250 lines of RTL.

## Test plan
- Reset: all outputs 0. Release reset, SPI write addr 0x10 data 0xA5 crc 0x3C -> rdy at N, o_wen=1 with addr 0x10 data 0xA5 crc 0x3C and o_spi_ctrl_reg_en=1 at N+1, o_spi_rsp_vld at N+2 with rdata 0x00.
- eFuse read addr 0x10 with bank returning 0xA5/0x3C -> o_efu_rsp_vld at N+2, rdata 0xA5, rcrc 0x3C, o_efuse_ctrl_reg_en=1 only in N+1.
- SPI and eFuse both valid from reset, each issuing 3 back-to-back requests -> grant order SPI, EFU, SPI, EFU, SPI, EFU, grants spaced exactly 3 cycles apart, the non-granted rdy never high.
- Read of an unmapped address 0xFF (bank drives 0) -> rsp_vld with rdata 0x00, rcrc 0x00, no hang.
- i_rst_n low during ACC of a write -> o_wen drops in the same cycle, no rsp_vld ever, FSM in IDLE. A request held across reset release is granted on the first cycle after release.
- Toggle i_test_st_reg_en / i_cfg_st_reg_en while idle -> o_test_st_reg_en / o_cfg_st_reg_en follow one cycle later, and o_wen/o_ren stay 0.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types for the register-bank bus arbiter: FSM states, owners, latched command.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_bus_pkg;

    // Bus widths; the command struct below is sized from these.
    localparam int RB_DW    = 8;
    localparam int RB_AW    = 8;
    localparam int RB_CRC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RSP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_SPI = 1'b0,
        OWN_EFU = 1'b1
    } owner_t;

    typedef struct packed {
        logic                wr;
        logic [RB_AW-1:0]    addr;
        logic [RB_DW-1:0]    wdata;
        logic [RB_CRC_W-1:0] crc;
    } cmd_t;

    // The requester that did not win last time gets priority on a tie.
    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_SPI) ? OWN_EFU : OWN_SPI;
    endfunction

endpackage

// File: rtl/reg_bus_arb_rr_arb2.sv
// Two-way round-robin grant between SPI and eFuse with a last-grant pointer.
// Latency: grant is combinational from requests; pointer updates on the grant edge.
// Backpressure: no grant while i_en is low; a held request simply waits.
module rr_arb2
    import reg_bus_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_en,
    input  logic   i_req_spi,
    input  logic   i_req_efu,
    output logic   o_gnt_spi,
    output logic   o_gnt_efu,
    output owner_t o_win
);

    owner_t last_q;

    // Pick the winner: a lone request wins, a tie goes to whoever was not granted last.
    always_comb begin
        o_win     = OWN_SPI;
        o_gnt_spi = 1'b0;
        o_gnt_efu = 1'b0;
        if (i_req_spi && i_req_efu) begin
            o_win = other_owner(last_q);
        end else if (i_req_efu) begin
            o_win = OWN_EFU;
        end
        if (i_en && (i_req_spi || i_req_efu)) begin
            o_gnt_spi = (o_win == OWN_SPI);
            o_gnt_efu = (o_win == OWN_EFU);
        end
    end

    // Remember the last winner; resets to eFuse so SPI takes the first tie.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= OWN_EFU;
        end else if (o_gnt_spi || o_gnt_efu) begin
            last_q <= o_win;
        end
    end

endmodule

// File: rtl/reg_bus_arb.sv
// Arbitrates SPI / eFuse register accesses onto the bank bus: grant, one-cycle strobe, one-cycle response.
// Latency: grant N, strobe N+1, response pulse N+2, next grant no earlier than N+3.
// Backpressure: rdy only in IDLE for the round-robin winner; requesters hold vld until rdy.
module reg_bus_arb
    import reg_bus_pkg::*;
#(
    parameter int DW    = RB_DW,
    parameter int AW    = RB_AW,
    parameter int CRC_W = RB_CRC_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    // SPI frame handler
    input  logic             i_spi_req_vld,
    input  logic             i_spi_req_wr,
    input  logic [AW-1:0]    i_spi_req_addr,
    input  logic [DW-1:0]    i_spi_req_wdata,
    input  logic [CRC_W-1:0] i_spi_req_crc,
    output logic             o_spi_req_rdy,
    output logic             o_spi_rsp_vld,
    // eFuse loader
    input  logic             i_efu_req_vld,
    input  logic             i_efu_req_wr,
    input  logic [AW-1:0]    i_efu_req_addr,
    input  logic [DW-1:0]    i_efu_req_wdata,
    input  logic [CRC_W-1:0] i_efu_req_crc,
    output logic             o_efu_req_rdy,
    output logic             o_efu_rsp_vld,
    // Shared response
    output logic [DW-1:0]    o_rsp_rdata,
    output logic [CRC_W-1:0] o_rsp_rcrc,
    // Mode inputs
    input  logic             i_test_st_reg_en,
    input  logic             i_cfg_st_reg_en,
    // Bank bus
    output logic             o_wen,
    output logic             o_ren,
    output logic [AW-1:0]    o_addr,
    output logic [DW-1:0]    o_wdata,
    output logic [CRC_W-1:0] o_crc_data,
    output logic             o_test_st_reg_en,
    output logic             o_cfg_st_reg_en,
    output logic             o_spi_ctrl_reg_en,
    output logic             o_efuse_ctrl_reg_en,
    input  logic [DW-1:0]    i_rdata,
    input  logic [CRC_W-1:0] i_rcrc
);

    state_t           state_q;
    state_t           state_d;
    cmd_t             cmd_q;
    owner_t           own_q;
    logic [DW-1:0]    rsp_rdata_q;
    logic [CRC_W-1:0] rsp_rcrc_q;
    logic             test_st_q;
    logic             cfg_st_q;

    logic             arb_en;
    logic             gnt_spi;
    logic             gnt_efu;
    logic             gnt_any;
    owner_t           win;

    // Gating with reset keeps every output, including rdy, low while reset is held.
    assign arb_en  = (state_q == IDLE) && i_rst_n;
    assign gnt_any = gnt_spi || gnt_efu;

    rr_arb2 u_rr_arb2 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (arb_en),
        .i_req_spi (i_spi_req_vld),
        .i_req_efu (i_efu_req_vld),
        .o_gnt_spi (gnt_spi),
        .o_gnt_efu (gnt_efu),
        .o_win     (win)
    );

    // State register; async reset aborts any in-flight access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE waits for a grant, ACC and RSP each last exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = gnt_any ? ACC : IDLE;
            ACC:     state_d = RSP;
            RSP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: strobes and owner enables only in ACC, response pulse only in RSP.
    always_comb begin
        o_spi_req_rdy       = gnt_spi;
        o_efu_req_rdy       = gnt_efu;
        o_wen               = 1'b0;
        o_ren               = 1'b0;
        o_spi_ctrl_reg_en   = 1'b0;
        o_efuse_ctrl_reg_en = 1'b0;
        o_spi_rsp_vld       = 1'b0;
        o_efu_rsp_vld       = 1'b0;
        case (state_q)
            ACC: begin
                o_wen               = cmd_q.wr;
                o_ren               = !cmd_q.wr;
                o_spi_ctrl_reg_en   = (own_q == OWN_SPI);
                o_efuse_ctrl_reg_en = (own_q == OWN_EFU);
            end
            RSP: begin
                o_spi_rsp_vld = (own_q == OWN_SPI);
                o_efu_rsp_vld = (own_q == OWN_EFU);
            end
            default: ;
        endcase
    end

    // Latch the winner's command at grant; it stays on the bus lines until the next grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q <= '0;
            own_q <= OWN_SPI;
        end else if (gnt_any) begin
            own_q <= win;
            if (win == OWN_EFU) begin
                cmd_q <= '{wr: i_efu_req_wr, addr: i_efu_req_addr,
                           wdata: i_efu_req_wdata, crc: i_efu_req_crc};
            end else begin
                cmd_q <= '{wr: i_spi_req_wr, addr: i_spi_req_addr,
                           wdata: i_spi_req_wdata, crc: i_spi_req_crc};
            end
        end
    end

    // Capture bank read data at the end of ACC; writes respond with zeros.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_rdata_q <= '0;
            rsp_rcrc_q  <= '0;
        end else if (state_q == ACC) begin
            rsp_rdata_q <= cmd_q.wr ? '0 : i_rdata;
            rsp_rcrc_q  <= cmd_q.wr ? '0 : i_rcrc;
        end
    end

    // Mode passthrough, registered every cycle regardless of the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            test_st_q <= 1'b0;
            cfg_st_q  <= 1'b0;
        end else begin
            test_st_q <= i_test_st_reg_en;
            cfg_st_q  <= i_cfg_st_reg_en;
        end
    end

    assign o_addr           = cmd_q.addr;
    assign o_wdata          = cmd_q.wdata;
    assign o_crc_data       = cmd_q.crc;
    assign o_rsp_rdata      = rsp_rdata_q;
    assign o_rsp_rcrc       = rsp_rcrc_q;
    assign o_test_st_reg_en = test_st_q;
    assign o_cfg_st_reg_en  = cfg_st_q;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Directed self-checking bench for reg_bus_arb.
// Latency: n/a.
// Backpressure: requesters hold vld until rdy is seen.
module tb_reg_bus_arb;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_spi_req_vld, i_spi_req_wr;
    logic [7:0] i_spi_req_addr, i_spi_req_wdata, i_spi_req_crc;
    logic       o_spi_req_rdy, o_spi_rsp_vld;
    logic       i_efu_req_vld, i_efu_req_wr;
    logic [7:0] i_efu_req_addr, i_efu_req_wdata, i_efu_req_crc;
    logic       o_efu_req_rdy, o_efu_rsp_vld;
    logic [7:0] o_rsp_rdata, o_rsp_rcrc;
    logic       i_test_st_reg_en, i_cfg_st_reg_en;
    logic       o_wen, o_ren;
    logic [7:0] o_addr, o_wdata, o_crc_data;
    logic       o_test_st_reg_en, o_cfg_st_reg_en;
    logic       o_spi_ctrl_reg_en, o_efuse_ctrl_reg_en;
    logic [7:0] i_rdata, i_rcrc;

    int checks = 0;
    int errors = 0;

    reg_bus_arb dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_spi_req_vld       (i_spi_req_vld),
        .i_spi_req_wr        (i_spi_req_wr),
        .i_spi_req_addr      (i_spi_req_addr),
        .i_spi_req_wdata     (i_spi_req_wdata),
        .i_spi_req_crc       (i_spi_req_crc),
        .o_spi_req_rdy       (o_spi_req_rdy),
        .o_spi_rsp_vld       (o_spi_rsp_vld),
        .i_efu_req_vld       (i_efu_req_vld),
        .i_efu_req_wr        (i_efu_req_wr),
        .i_efu_req_addr      (i_efu_req_addr),
        .i_efu_req_wdata     (i_efu_req_wdata),
        .i_efu_req_crc       (i_efu_req_crc),
        .o_efu_req_rdy       (o_efu_req_rdy),
        .o_efu_rsp_vld       (o_efu_rsp_vld),
        .o_rsp_rdata         (o_rsp_rdata),
        .o_rsp_rcrc          (o_rsp_rcrc),
        .i_test_st_reg_en    (i_test_st_reg_en),
        .i_cfg_st_reg_en     (i_cfg_st_reg_en),
        .o_wen               (o_wen),
        .o_ren               (o_ren),
        .o_addr              (o_addr),
        .o_wdata             (o_wdata),
        .o_crc_data          (o_crc_data),
        .o_test_st_reg_en    (o_test_st_reg_en),
        .o_cfg_st_reg_en     (o_cfg_st_reg_en),
        .o_spi_ctrl_reg_en   (o_spi_ctrl_reg_en),
        .o_efuse_ctrl_reg_en (o_efuse_ctrl_reg_en),
        .i_rdata             (i_rdata),
        .i_rcrc              (i_rcrc)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge i_clk);
    endtask

    initial begin
        int         g_cnt;
        int         g_cyc[6];
        logic       g_own[6];
        logic       exp_own[6];
        int         spi_left, efu_left;
        logic       spi_acc, efu_acc;
        logic       got;
        logic [7:0] rd, rc;

        i_rst_n = 1'b0;
        i_spi_req_vld = 0; i_spi_req_wr = 0; i_spi_req_addr = 0; i_spi_req_wdata = 0; i_spi_req_crc = 0;
        i_efu_req_vld = 0; i_efu_req_wr = 0; i_efu_req_addr = 0; i_efu_req_wdata = 0; i_efu_req_crc = 0;
        i_test_st_reg_en = 0; i_cfg_st_reg_en = 0;
        i_rdata = 8'hA5; i_rcrc = 8'h3C;

        // Reset state
        smp(); smp();
        chk("rst_wen", o_wen, 0);
        chk("rst_ren", o_ren, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_rdata", o_rsp_rdata, 0);
        chk("rst_spi_rsp", o_spi_rsp_vld, 0);
        chk("rst_ctrl_en", {o_spi_ctrl_reg_en, o_efuse_ctrl_reg_en}, 0);

        // SPI write 0x10 / 0xA5 / 0x3C; bank drives A5 but a write must respond with 0
        step();
        i_rst_n = 1'b1;
        i_spi_req_vld = 1; i_spi_req_wr = 1; i_spi_req_addr = 8'h10; i_spi_req_wdata = 8'hA5; i_spi_req_crc = 8'h3C;
        smp();
        chk("w_spi_rdy", o_spi_req_rdy, 1);
        chk("w_efu_rdy", o_efu_req_rdy, 0);
        chk("w_idle_wen", o_wen, 0);
        step();
        i_spi_req_vld = 0;
        smp();
        chk("w_wen", o_wen, 1);
        chk("w_ren", o_ren, 0);
        chk("w_addr", o_addr, 8'h10);
        chk("w_wdata", o_wdata, 8'hA5);
        chk("w_crc", o_crc_data, 8'h3C);
        chk("w_spi_ctrl", o_spi_ctrl_reg_en, 1);
        chk("w_efu_ctrl", o_efuse_ctrl_reg_en, 0);
        chk("w_acc_rsp", o_spi_rsp_vld, 0);
        step();
        smp();
        chk("w_rsp_vld", o_spi_rsp_vld, 1);
        chk("w_rsp_rdata", o_rsp_rdata, 8'h00);
        chk("w_rsp_rcrc", o_rsp_rcrc, 8'h00);
        chk("w_rsp_wen", o_wen, 0);
        chk("w_rsp_ctrl", o_spi_ctrl_reg_en, 0);

        // eFuse read 0x10 with bank returning A5/3C
        step();
        i_efu_req_vld = 1; i_efu_req_wr = 0; i_efu_req_addr = 8'h10;
        smp();
        chk("r_efu_rdy", o_efu_req_rdy, 1);
        chk("r_spi_rdy", o_spi_req_rdy, 0);
        step();
        i_efu_req_vld = 0;
        smp();
        chk("r_ren", o_ren, 1);
        chk("r_wen", o_wen, 0);
        chk("r_addr", o_addr, 8'h10);
        chk("r_efu_ctrl", o_efuse_ctrl_reg_en, 1);
        chk("r_spi_ctrl", o_spi_ctrl_reg_en, 0);
        step();
        smp();
        chk("r_efu_rsp", o_efu_rsp_vld, 1);
        chk("r_spi_rsp", o_spi_rsp_vld, 0);
        chk("r_rdata", o_rsp_rdata, 8'hA5);
        chk("r_rcrc", o_rsp_rcrc, 8'h3C);
        chk("r_rsp_ctrl", o_efuse_ctrl_reg_en, 0);

        // Both requesters valid from reset, three back-to-back requests each
        step();
        i_rst_n = 1'b0;
        smp();
        step();
        i_rst_n = 1'b1;
        spi_left = 3; efu_left = 3; g_cnt = 0;
        exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 0; exp_own[3] = 1; exp_own[4] = 0; exp_own[5] = 1;
        i_spi_req_vld = 1; i_spi_req_wr = 1; i_spi_req_addr = 8'h20;
        i_efu_req_vld = 1; i_efu_req_wr = 0; i_efu_req_addr = 8'h30;
        for (int c = 0; c < 40; c++) begin
            smp();
            chk("rr_dual_rdy", o_spi_req_rdy & o_efu_req_rdy, 0);
            spi_acc = o_spi_req_rdy;
            efu_acc = o_efu_req_rdy;
            if (spi_acc || efu_acc) begin
                if (g_cnt < 6) begin
                    g_own[g_cnt] = efu_acc;
                    g_cyc[g_cnt] = c;
                end
                g_cnt++;
            end
            step();
            if (spi_acc) spi_left--;
            if (efu_acc) efu_left--;
            i_spi_req_vld = (spi_left > 0);
            i_efu_req_vld = (efu_left > 0);
            i_spi_req_addr = 8'h20 + 8'(spi_left);
            i_efu_req_addr = 8'h30 + 8'(efu_left);
        end
        chk("rr_grant_count", g_cnt, 6);
        chk("rr_first_grant_cycle", g_cyc[0], 0);
        for (int i = 0; i < 6; i++) chk($sformatf("rr_owner_%0d", i), g_own[i], exp_own[i]);
        for (int i = 1; i < 6; i++) chk($sformatf("rr_spacing_%0d", i), g_cyc[i] - g_cyc[i-1], 3);

        // Unmapped read 0xFF: bank drives 0, previous response held A5
        i_rdata = 8'h00; i_rcrc = 8'h00;
        i_spi_req_vld = 1; i_spi_req_wr = 0; i_spi_req_addr = 8'hFF;
        smp();
        chk("um_rdy", o_spi_req_rdy, 1);
        step();
        i_spi_req_vld = 0;
        smp();
        chk("um_ren", o_ren, 1);
        chk("um_addr", o_addr, 8'hFF);
        got = 0; rd = 8'hEE; rc = 8'hEE;
        for (int k = 0; k < 5 && !got; k++) begin
            step();
            smp();
            if (o_spi_rsp_vld) begin
                got = 1; rd = o_rsp_rdata; rc = o_rsp_rcrc;
            end
        end
        chk("um_rsp_seen", got, 1);
        chk("um_rdata", rd, 8'h00);
        chk("um_rcrc", rc, 8'h00);

        // Reset during ACC of a write, with the next request held across reset
        step();
        i_spi_req_vld = 1; i_spi_req_wr = 1; i_spi_req_addr = 8'h22; i_spi_req_wdata = 8'h5A; i_spi_req_crc = 8'h11;
        smp();
        chk("ab_rdy", o_spi_req_rdy, 1);
        step();
        i_spi_req_wr = 0; i_spi_req_addr = 8'h33;
        #1;
        chk("ab_wen_before", o_wen, 1);
        i_rst_n = 1'b0;
        #1;
        chk("ab_wen_drop", o_wen, 0);
        chk("ab_ctrl_drop", o_spi_ctrl_reg_en, 0);
        chk("ab_rdy_in_rst", o_spi_req_rdy, 0);
        smp();
        chk("ab_no_rsp_0", o_spi_rsp_vld, 0);
        step();
        smp();
        chk("ab_no_rsp_1", o_spi_rsp_vld, 0);
        step();
        i_rst_n = 1'b1;
        i_rdata = 8'h77; i_rcrc = 8'hE1;
        smp();
        chk("ab_rdy_after_rel", o_spi_req_rdy, 1);
        chk("ab_no_rsp_2", o_spi_rsp_vld, 0);
        step();
        i_spi_req_vld = 0;
        smp();
        chk("ab_ren", o_ren, 1);
        chk("ab_addr", o_addr, 8'h33);
        step();
        smp();
        chk("ab_rsp_vld", o_spi_rsp_vld, 1);
        chk("ab_rdata", o_rsp_rdata, 8'h77);
        chk("ab_rcrc", o_rsp_rcrc, 8'hE1);

        // Mode passthrough while idle
        step();
        i_test_st_reg_en = 1;
        smp();
        chk("md_test_lag", o_test_st_reg_en, 0);
        step();
        smp();
        chk("md_test_on", o_test_st_reg_en, 1);
        chk("md_cfg_off", o_cfg_st_reg_en, 0);
        chk("md_strobes_0", {o_wen, o_ren}, 0);
        step();
        i_test_st_reg_en = 0; i_cfg_st_reg_en = 1;
        smp();
        chk("md_cfg_lag", o_cfg_st_reg_en, 0);
        step();
        smp();
        chk("md_test_off", o_test_st_reg_en, 0);
        chk("md_cfg_on", o_cfg_st_reg_en, 1);
        chk("md_strobes_1", {o_wen, o_ren}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
